// File: rtl/sar_pkg.sv
// Shared definitions for the multi-channel SAR ADC controller:
// FSM state encoding, mode constants and derived-width helper.
package sar_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SAMPLE = 2'd1,
        ST_CONV   = 2'd2,
        ST_OUT    = 2'd3
    } sar_state_e;

    localparam logic MODE_SINGLE = 1'b0;
    localparam logic MODE_SCAN   = 1'b1;

    // Index width for n items, never narrower than one bit.
    function automatic int ch_width(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/sar_bit_engine.sv
// WIDTH-bit successive-approximation register pair: trial mask and
// accumulated result, presenting dac = res | mask to the DAC.
module sar_bit_engine #(
    parameter int WIDTH = 10
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             load_i,
    input  logic             step_i,
    input  logic             clear_i,
    input  logic             cmp_i,
    output logic [WIDTH-1:0] dac_o,
    output logic             last_o,
    output logic [WIDTH-1:0] res_o
);

    localparam logic [WIDTH-1:0] MSB = {1'b1, {(WIDTH-1){1'b0}}};

    logic [WIDTH-1:0] mask_q;
    logic [WIDTH-1:0] res_q;

    // Shifting the mask past bit 0 leaves it all-zero, which is the
    // cleared state expected after the final trial.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            mask_q <= '0;
            res_q  <= '0;
        end else if (clear_i) begin
            mask_q <= '0;
            res_q  <= '0;
        end else if (load_i) begin
            mask_q <= MSB;
            res_q  <= '0;
        end else if (step_i) begin
            if (cmp_i) begin
                res_q <= res_q | mask_q;
            end
            mask_q <= mask_q >> 1;
        end
    end

    assign dac_o  = res_q | mask_q;
    assign last_o = mask_q[0];
    assign res_o  = res_q;

endmodule

// File: rtl/sar_ctrl_mc.sv
// Multi-channel SAR ADC controller: single-channel or scan conversion,
// results tagged with their channel over a valid/ready handshake.
module sar_ctrl_mc
    import sar_pkg::*;
#(
    parameter int WIDTH         = 10,
    parameter int CHANNELS      = 4,
    parameter int SAMPLE_CYCLES = 2,
    localparam int CH_W         = ch_width(CHANNELS)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic             scan_i,
    input  logic [CH_W-1:0]  ch_sel_i,
    input  logic             abort_i,
    input  logic             cmp_i,
    output logic [CH_W-1:0]  mux_o,
    output logic             sample_o,
    output logic [WIDTH-1:0] dac_o,
    output logic             busy_o,
    output logic [WIDTH-1:0] result_o,
    output logic [CH_W-1:0]  ch_o,
    output logic             valid_o,
    input  logic             ready_i,
    output logic             eoc_o
);

    localparam int              SC_W    = ch_width(SAMPLE_CYCLES);
    localparam logic [SC_W-1:0] SC_LOAD = SC_W'(SAMPLE_CYCLES - 1);
    localparam logic [CH_W-1:0] CH_LAST = CH_W'(CHANNELS - 1);

    sar_state_e       state_q, state_d;
    logic             scan_q;
    logic [CH_W-1:0]  chan_q;
    logic [CH_W-1:0]  chan_start;
    logic [SC_W-1:0]  scnt_q;
    logic [WIDTH-1:0] result_q;
    logic [CH_W-1:0]  ch_q;
    logic             valid_q;
    logic             sample_q;
    logic             more_ch;
    logic             eoc_d;

    logic             eng_load, eng_step, eng_clear, eng_last;
    logic [WIDTH-1:0] eng_dac, eng_res;

    sar_bit_engine #(
        .WIDTH (WIDTH)
    ) u_engine (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .load_i  (eng_load),
        .step_i  (eng_step),
        .clear_i (eng_clear),
        .cmp_i   (cmp_i),
        .dac_o   (eng_dac),
        .last_o  (eng_last),
        .res_o   (eng_res)
    );

    always_comb begin
        chan_start = ch_sel_i;
        if (scan_i == MODE_SCAN) begin
            chan_start = '0;
        end else if (int'(ch_sel_i) >= CHANNELS) begin
            chan_start = CH_LAST;
        end
    end

    assign more_ch = (scan_q == MODE_SCAN) && (chan_q != CH_LAST);

    always_comb begin
        state_d   = state_q;
        eng_load  = 1'b0;
        eng_step  = 1'b0;
        eng_clear = 1'b0;
        eoc_d     = 1'b0;
        if (abort_i) begin
            state_d   = ST_IDLE;
            eng_clear = 1'b1;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start_i) state_d = ST_SAMPLE;
                end
                ST_SAMPLE: begin
                    if (scnt_q == '0) begin
                        state_d  = ST_CONV;
                        eng_load = 1'b1;
                    end
                end
                ST_CONV: begin
                    eng_step = 1'b1;
                    if (eng_last) state_d = ST_OUT;
                end
                ST_OUT: begin
                    if (ready_i) begin
                        if (more_ch) begin
                            state_d = ST_SAMPLE;
                        end else begin
                            state_d = ST_IDLE;
                            eoc_d   = 1'b1;
                        end
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= ST_IDLE;
            scan_q   <= MODE_SINGLE;
            chan_q   <= '0;
            scnt_q   <= '0;
            result_q <= '0;
            ch_q     <= '0;
            valid_q  <= 1'b0;
            sample_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            sample_q <= (state_d == ST_SAMPLE);
            if (abort_i) begin
                valid_q <= 1'b0;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        if (start_i) begin
                            scan_q <= scan_i;
                            chan_q <= chan_start;
                            scnt_q <= SC_LOAD;
                        end
                    end
                    ST_SAMPLE: begin
                        if (scnt_q != '0) scnt_q <= scnt_q - SC_W'(1);
                    end
                    ST_CONV: begin
                        // Final result folds in the last trial bit directly.
                        if (eng_last) begin
                            result_q <= cmp_i ? eng_dac : eng_res;
                            ch_q     <= chan_q;
                            valid_q  <= 1'b1;
                        end
                    end
                    ST_OUT: begin
                        if (ready_i) begin
                            valid_q <= 1'b0;
                            if (more_ch) begin
                                chan_q <= chan_q + CH_W'(1);
                                scnt_q <= SC_LOAD;
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign mux_o    = chan_q;
    assign sample_o = sample_q;
    assign dac_o    = eng_dac;
    assign busy_o   = (state_q != ST_IDLE);
    assign result_o = result_q;
    assign ch_o     = ch_q;
    assign valid_o  = valid_q;
    assign eoc_o    = eoc_d;

endmodule
